wb_regfile: RTL

//  Writeback-side consumer of the MEM/WB pipeline register: selects writeback data
//  (ALU result vs load data), commits it to a 2^ADDR_W x DATA_W scalar register file,
//  and serves two combinational read ports to decode with same-cycle write-through bypass.

---
 rtl/wb_regfile_pkg.sv | 11 +
 rtl/wb_regfile_bypass_mux.sv | 27 ++
 rtl/wb_regfile.sv | 98 +++++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback / register-file slice.
package wb_regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 32;

  // Index of the hardwired-zero register
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/wb_regfile_bypass_mux.sv
// Priority read mux for one register-file read port:
// zero register, then same-cycle writeback bypass, then stored value.
module wb_bypass_mux
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_commit,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic [DATA_W-1:0] o_rd_data
);

  // Zero register wins over bypass so r0 can never be observed non-zero
  always_comb begin
    o_rd_data = i_rf_data;
    if (i_rd_addr == ADDR_W'(REG_ZERO)) begin
      o_rd_data = '0;
    end else if (i_commit && (i_rd_addr == i_wr_addr)) begin
      o_rd_data = i_wr_data;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects writeback data, commits it to the register file,
// serves two bypassed read ports and tracks a commit counter / strobe.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_valid_o,
  output logic [CNT_W-1:0]  wb_count_o
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_rf [NUM_REGS];
  logic              r_valid;
  logic [CNT_W-1:0]  r_count;

  logic              w_commit;
  logic [DATA_W-1:0] w_wb_data;
  logic [DATA_W-1:0] w_rs_rf;
  logic [DATA_W-1:0] w_rt_rf;

  // Writeback data select and commit qualification (writes to r0 are dropped)
  always_comb begin
    w_wb_data = MemtoReg_i ? read_data_i : alu_result_i;
    w_commit  = RegWrite_i && (write_addr_i != ADDR_W'(REG_ZERO));
  end

  assign w_rs_rf   = r_rf[rs_addr_i];
  assign w_rt_rf   = r_rf[rt_addr_i];
  assign wb_data_o = w_wb_data;

  // Register storage; async clear so reset discards any in-flight write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_commit) begin
      r_rf[write_addr_i] <= w_wb_data;
    end
  end

  // Commit strobe and wrapping commit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_valid <= w_commit;
      if (w_commit) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign wb_valid_o = r_valid;
  assign wb_count_o = r_count;

  wb_bypass_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rs_mux (
    .i_rd_addr (rs_addr_i),
    .i_commit  (w_commit),
    .i_wr_addr (write_addr_i),
    .i_wr_data (w_wb_data),
    .i_rf_data (w_rs_rf),
    .o_rd_data (rs_data_o)
  );

  wb_bypass_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rt_mux (
    .i_rd_addr (rt_addr_i),
    .i_commit  (w_commit),
    .i_wr_addr (write_addr_i),
    .i_wr_data (w_wb_data),
    .i_rf_data (w_rt_rf),
    .o_rd_data (rt_data_o)
  );

endmodule
